branch_ras_unit: RTL
====================

BRANCH_RAS_UNIT -- requirements
Module: branch_ras_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning PC/target address width.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, meaning number of return-address stack entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port valid_in  input  1  branch request qualifier.
REQ-006 SHALL have port stall  input  1  pipeline stall; request and state frozen while high.
REQ-007 SHALL have port btype  input  3  branch type: 000 NONE, 001 JZ, 010 JN, 011 JC, 100 JV, 101 LOOP, 110 JMP, 111 RET.
REQ-008 SHALL have port is_call  input  1  with btype=JMP, marks CALL (push return address).
REQ-009 SHALL have port flag_mask  input  4  bit0 Z, bit1 N, bit2 C, bit3 V.
REQ-010 SHALL have port pc_next  input  ADDR_W  return address pushed on CALL.
REQ-011 SHALL have port target_in  input  ADDR_W  decoded branch target for non-RET branches.
REQ-012 SHALL have port b_take  output  1  registered taken pulse.
REQ-013 SHALL have port b_target  output  ADDR_W  registered redirect address, valid when b_take=1.
REQ-014 SHALL have port ras_empty, ras_full  output  1 each  stack occupancy status.
REQ-015 SHALL have port ras_ovf, ras_unf  output  1 each  sticky overflow/underflow error flags.

Function
REQ-016 SHALL evaluate taken when valid_in=1, stall=0: NONE never; JZ Z=1; JN N=1; JC C=1; JV V=1; LOOP Z=0; JMP and RET always; undefined codes never.
REQ-017 SHALL register b_take and b_target with 1-cycle latency; b_take is a single-cycle pulse per accepted request, else 0.
REQ-018 SHALL set b_target=target_in for taken non-RET branches; =popped stack entry for RET.
REQ-019 SHALL, on accepted CALL, write pc_next at top pointer and increment occupancy count (width clog2(RAS_DEPTH)+1).
REQ-020 SHALL, on accepted RET, decrement pointer and output that entry in the same registered cycle.
REQ-021 SHALL, on CALL when full, overwrite oldest entry (circular wrap), keep count=RAS_DEPTH, set ras_ovf.
REQ-022 SHALL, on RET when empty, still take with b_target=0, leave pointer/count unchanged, set ras_unf.
REQ-023 SHALL hold all state, and force b_take=0, in any cycle with stall=1 or valid_in=0.
REQ-024 SHALL derive ras_empty (count=0) and ras_full (count=RAS_DEPTH) combinationally from registered count.
REQ-025 SHALL ignore is_call unless btype=JMP.

Reset
REQ-026 SHALL on rst_n=0 at clk edge clear b_take, b_target, pointer, count, ras_ovf, ras_unf; ras_empty=1, ras_full=0.
REQ-027 SHALL give reset priority over any concurrent request, discarding it; stack contents need not be cleared.
REQ-028 SHALL clear ras_ovf/ras_unf only by reset.

Configuration
REQ-029 SHALL compile the return-address stack only when BRANCH_RAS_EN is defined.
REQ-030 SHALL, without BRANCH_RAS_EN, use b_target=target_in for RET, ignore is_call, tie ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0.

Verification
REQ-031 SHALL cover: reset, JZ flag_mask=0001 target_in=0x40 -> next cycle b_take=1, b_target=0x40; flag_mask=0000 -> b_take=0.
REQ-032 SHALL cover: LOOP with Z=0 -> taken; Z=1 -> not taken; btype=NONE -> b_take=0 regardless of flags.
REQ-033 SHALL cover: CALL pc_next=0x11,0x22 then RET,RET -> b_target 0x22 then 0x11, ras_empty=1 after.
REQ-034 SHALL cover: 5 CALLs (0x01..0x05) with RAS_DEPTH=4 -> ras_full=1, ras_ovf=1; 4 RETs -> 0x05,0x04,0x03,0x02.
REQ-035 SHALL cover: RET on empty -> b_take=1, b_target=0, ras_unf=1 sticky until rst_n=0.
REQ-036 SHALL cover: stall=1 with valid CALL -> count unchanged, b_take=0; rst_n=0 with concurrent CALL -> count=0.

Source files
------------

// File: rtl/branch_ras_unit.sv
// branch_ras_unit: branch condition evaluation with a registered redirect
// (b_take/b_target, one cycle of latency) and an optional circular
// return-address stack.
// Optional feature macro: BRANCH_RAS_EN. When it is defined, the
// return-address stack is built. When it is not defined, RET redirects to
// target_in and the stack status outputs are tied off.
module branch_ras_unit #(
  parameter int ADDR_W    = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              stall,
  input  logic [2:0]        btype,
  input  logic              is_call,
  input  logic [3:0]        flag_mask,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic [ADDR_W-1:0] target_in,
  output logic              b_take,
  output logic [ADDR_W-1:0] b_target,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);
  localparam logic [2:0] BT_JZ   = 3'b001;
  localparam logic [2:0] BT_JN   = 3'b010;
  localparam logic [2:0] BT_JC   = 3'b011;
  localparam logic [2:0] BT_JV   = 3'b100;
  localparam logic [2:0] BT_LOOP = 3'b101;
  localparam logic [2:0] BT_JMP  = 3'b110;
  localparam logic [2:0] BT_RET  = 3'b111;

  logic              accept;
  logic              taken;
  logic              b_take_d, b_take_q;
  logic [ADDR_W-1:0] b_target_d, b_target_q;

  // A request counts only when it is qualified and the pipe is not stalled
  assign accept = valid_in & ~stall;

  // Branch condition from the type code and the flags
  always_comb begin
    taken = 1'b0;
    case (btype)
      BT_JZ:          taken = flag_mask[0];
      BT_JN:          taken = flag_mask[1];
      BT_JC:          taken = flag_mask[2];
      BT_JV:          taken = flag_mask[3];
      BT_LOOP:        taken = ~flag_mask[0];
      BT_JMP, BT_RET: taken = 1'b1;
      default:        taken = 1'b0;
    endcase
  end

`ifdef BRANCH_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [RAS_DEPTH-1:0][ADDR_W-1:0] stack_q, stack_d;
  logic [PTR_W-1:0]                 ptr_q, ptr_d, ptr_dec;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             ovf_q, ovf_d, unf_q, unf_d;
  logic                             empty, full;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ptr_dec = ptr_q - PTR_W'(1);

  // Redirect and stack update. A CALL on a full stack wraps the pointer,
  // overwriting the oldest entry. A RET on an empty stack still redirects,
  // to address 0.
  always_comb begin
    b_take_d   = accept & taken;
    b_target_d = b_target_q;
    stack_d    = stack_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (accept && taken) b_target_d = target_in;
    if (accept && btype == BT_JMP && is_call) begin
      stack_d[ptr_q] = pc_next;
      ptr_d          = ptr_q + PTR_W'(1);
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + CNT_W'(1);
    end
    if (accept && btype == BT_RET) begin
      if (empty) begin
        b_target_d = '0;
        unf_d      = 1'b1;
      end else begin
        ptr_d      = ptr_dec;
        cnt_d      = cnt_q - CNT_W'(1);
        b_target_d = stack_q[ptr_dec];
      end
    end
  end

  // Stack pointer, occupancy and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage is not reset. A request that arrives during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n) stack_q <= stack_d;
  end

  assign ras_empty = empty;
  assign ras_full  = full;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;
`else
  // Redirect only. RET uses the decoded target like any other branch.
  always_comb begin
    b_take_d   = accept & taken;
    b_target_d = b_target_q;
    if (accept && taken) b_target_d = target_in;
  end

  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = 1'b0;

  logic unused_ras;
  assign unused_ras = &{1'b0, is_call, pc_next};
`endif

  // Registered redirect outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_take_q   <= 1'b0;
      b_target_q <= '0;
    end else begin
      b_take_q   <= b_take_d;
      b_target_q <= b_target_d;
    end
  end

  assign b_take   = b_take_q;
  assign b_target = b_target_q;
endmodule
